led_fade_pwm: RTL and testbench

Downstream output stage for the flowing-light pattern generator. Takes its active-low 3-bit RGB pattern and drives the physical LED pins through per-channel PWM. Channels fade in and out over a programmable ramp instead of switching hard, giving a crossfade between successive lamps. Sits between the pattern generator and the top-level LED pins, on the same 50 MHz clock.

---
 rtl/led_fade_pwm.sv | 94 +++++++++
 tb/tb_led_fade_pwm.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/led_fade_pwm.sv
// Purpose: per-channel PWM LED driver that crossfades the active-low RGB pattern over a programmable ramp.
// Latency: led_in -> target 1 clk, -> duty 2 clk (snap mode), -> led_pwm pin 3 clk; ramps advance once per STEP_MAX+1 clocks.
// Backpressure: none; led_in is sampled every clock and only the latest target is followed (no queueing).
module led_fade_pwm #(
  parameter logic [15:0] STEP_MAX = 16'd48_827
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [2:0] led_in,
  input  logic       fade_en,
  output logic [2:0] led_pwm,
  output logic       busy
);

  logic [2:0]      target;
  logic [15:0]     step_cnt;
  logic            step_tick;
  logic [2:0][7:0] duty;
  logic [7:0]      pwm_cnt;

  assign step_tick = (step_cnt == STEP_MAX);

  // Latch the desired lamp state (active-high internally) every clock.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      target <= 3'b000;
    end else begin
      target <= ~led_in;
    end
  end

  // Free-running duty-step prescaler; a pattern change never restarts it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      step_cnt <= 16'd0;
    end else if (step_tick) begin
      step_cnt <= 16'd0;
    end else begin
      step_cnt <= step_cnt + 16'd1;
    end
  end

  // PWM phase counter with a 255-clock period so duty 255 is fully on.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pwm_cnt <= 8'd0;
    end else if (pwm_cnt == 8'd254) begin
      pwm_cnt <= 8'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // Per-channel duty: snap to the endpoint, or move one step toward it per tick, saturating.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      duty <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!fade_en) begin
          duty[i] <= target[i] ? 8'hFF : 8'h00;
        end else if (step_tick) begin
          if (target[i] && (duty[i] != 8'hFF)) begin
            duty[i] <= duty[i] + 8'd1;
          end else if (!target[i] && (duty[i] != 8'h00)) begin
            duty[i] <= duty[i] - 8'd1;
          end
        end
      end
    end
  end

  // Registered active-low pin drive: low for exactly duty clocks per PWM period.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led_pwm <= 3'b111;
    end else begin
      for (int i = 0; i < 3; i++) begin
        led_pwm[i] <= ~(duty[i] > pwm_cnt);
      end
    end
  end

  // Busy while any channel has not yet reached the endpoint of its current target.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (duty[i] != (target[i] ? 8'hFF : 8'h00)) begin
        busy = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Purpose: self-checking bench for led_fade_pwm against a cycle-count based behavioural model.
// Latency: model checks pins and busy 1 time unit after every rising edge.
// Backpressure: none; a second instance with a slow prescaler measures PWM duty accuracy.
module tb_led_fade_pwm;

  localparam int SM  = 3;
  localparam int SM2 = 1023;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] led_in = 3'b111;
  logic       fade_en = 1'b1;
  logic [2:0] led_pwm;
  logic       busy;

  logic       rst2_n = 1'b1;
  logic [2:0] led2_pwm;
  logic       busy2;
  logic       done2 = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: edge count since reset release drives both prescaler and PWM phase.
  int         m_k;
  bit   [2:0] m_tgt;
  int         m_duty [3];
  logic [2:0] m_pin;

  led_fade_pwm #(.STEP_MAX(16'(SM))) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .led_in(led_in), .fade_en(fade_en),
    .led_pwm(led_pwm), .busy(busy)
  );

  led_fade_pwm #(.STEP_MAX(16'(SM2))) dut2 (
    .sys_clk(clk), .sys_rst_n(rst2_n), .led_in(3'b110), .fade_en(1'b1),
    .led_pwm(led2_pwm), .busy(busy2)
  );

  always #10 if (clk_run) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_k   = 0;
    m_tgt = 3'b000;
    for (int i = 0; i < 3; i++) m_duty[i] = 0;
    m_pin = 3'b111;
  endtask

  function automatic logic model_busy();
    logic b;
    b = 1'b0;
    for (int i = 0; i < 3; i++)
      if (m_duty[i] != (m_tgt[i] ? 255 : 0)) b = 1'b1;
    return b;
  endfunction

  // One rising edge: pins from current duty vs PWM phase, duty moves toward its endpoint.
  task automatic model_edge();
    bit tick;
    int phase;
    int endp;
    tick  = ((m_k % (SM + 1)) == SM);
    phase = m_k % 255;
    for (int i = 0; i < 3; i++) begin
      m_pin[i] = !(m_duty[i] > phase);
      endp = m_tgt[i] ? 255 : 0;
      if (!fade_en) m_duty[i] = endp;
      else if (tick) begin
        if (m_duty[i] < endp) m_duty[i]++;
        else if (m_duty[i] > endp) m_duty[i]--;
      end
    end
    m_tgt = ~led_in;
    m_k++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("pwm", 32'(led_pwm), 32'(m_pin));
    check("busy", 32'(busy), 32'(model_busy()));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Main sequence on the fast-prescaler instance.
  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_pwm_noclk", 32'(led_pwm), 32'h7);
    check("rst_busy_noclk", 32'(busy), 32'h0);
    #2;
    led_in  = 3'b110;
    fade_en = 1'b1;
    model_reset();
    rst_n   = 1'b1;
    clk_run = 1'b1;

    // Ramp channel 0 up from reset.
    step();
    check("ramp_busy_start", 32'(busy), 32'h1);
    run(1040);
    check("ramp_pin0_on", 32'(led_pwm[0]), 32'h0);
    check("ramp_busy_done", 32'(busy), 32'h0);

    // Snap mode: pin follows two edges after target.
    fade_en = 1'b0;
    led_in  = 3'b111;
    run(4);
    led_in = 3'b011;
    run(2);
    check("snap_pin2_before", 32'(led_pwm[2]), 32'h1);
    step();
    check("snap_pin2_on", 32'(led_pwm[2]), 32'h0);
    run(20);
    check("snap_pin2_hold", 32'(led_pwm[2]), 32'h0);
    led_in = 3'b111;
    run(3);
    check("snap_pin2_off", 32'(led_pwm[2]), 32'h1);

    // Reversal mid-ramp, then full crossfade between channels 0 and 1.
    fade_en = 1'b1;
    led_in  = 3'b110;
    run(400);
    led_in = 3'b111;
    run(420);
    check("rev_pins_off", 32'(led_pwm), 32'h7);
    check("rev_busy_done", 32'(busy), 32'h0);
    led_in = 3'b110;
    run(1040);
    led_in = 3'b101;
    run(1040);
    check("xfade_pins", 32'(led_pwm), 32'h5);
    check("xfade_busy", 32'(busy), 32'h0);

    // fade_en drops while channel 0 is at duty 40 and rising.
    led_in = 3'b110;
    for (int w = 0; w < 400 && m_duty[0] != 40; w++) step();
    check("reach_duty40", 32'(m_duty[0]), 32'd40);
    fade_en = 1'b0;
    run(2);
    check("fadeoff_pin0_on", 32'(led_pwm[0]), 32'h0);
    check("fadeoff_busy", 32'(busy), 32'h0);

    // Randomized pattern and fade_en activity.
    fade_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) led_in = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) fade_en = ~fade_en;
      step();
    end

    // Asynchronous reset mid-ramp.
    fade_en = 1'b1;
    led_in  = 3'b110;
    run(300);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pwm", 32'(led_pwm), 32'h7);
    check("midrst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    model_reset();
    led_in = 3'($urandom_range(0, 7));
    rst_n  = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) led_in = 3'($urandom_range(0, 7));
      step();
    end

    for (int w = 0; w < 40000 && !done2; w++) @(posedge clk);
    check("dut2_done", 32'(done2), 32'h1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Duty accuracy: after 32 ticks of a 1024-clock prescaler, one PWM period has exactly 32 low cycles.
  initial begin
    int lows;
    int highs;
    #1 rst2_n = 1'b0;
    wait (clk_run);
    rst2_n = 1'b1;
    for (int e = 0; e < 32800; e++) @(posedge clk);
    lows  = 0;
    highs = 0;
    for (int e = 0; e < 255; e++) begin
      @(posedge clk);
      #1;
      if (led2_pwm[0] == 1'b0) lows++;
      else highs++;
    end
    check("acc_low_cycles", 32'(lows), 32'd32);
    check("acc_high_cycles", 32'(highs), 32'd223);
    check("acc_other_pins", 32'(led2_pwm[2:1]), 32'h3);
    check("acc_busy", 32'(busy2), 32'h1);
    done2 = 1'b1;
  end

endmodule
